// File: rtl/pdma_pkg.sv
// pdma_pkg: shared PDMA constants and drain-state encoding for producer and consumer sides
package pdma_pkg;
  localparam int PDMA_DATA_W = 32;
  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/pdma_fifo_mem.sv
// pdma_fifo_mem: DEPTH x DATA_W RAM, registered write, asynchronous read (LSRAM/uSRAM friendly)
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata combinational read port.
module pdma_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pdma_fifo_src.sv
// pdma_fifo_src: show-ahead sample FIFO that requests a PDMA drain burst on threshold or timeout
// Ports: clk, rstb (sync active-low); wr_en/wr_data producer push; full, level, overflow status;
// clr_err clears overflow; pdma_irq_req/pdma_data_rdy/pdma_rdata/pdma_fifo_pop consumer handshake.
module pdma_fifo_src
  import pdma_pkg::*;
#(
  parameter int DATA_W     = PDMA_DATA_W,
  parameter int DEPTH      = 16,
  parameter int IRQ_THRESH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     pdma_irq_req,
  output logic                     pdma_data_rdy,
  input  logic                     pdma_fifo_pop,
  output logic [DATA_W-1:0]        pdma_rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_lvl_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state, w_state_nxt;
  logic          r_full, r_rdy, r_irq, r_ovf;
  logic          w_pop_acc, w_wr_acc, w_tmo;
  pdma_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_raddr (r_rptr),
    .o_rdata (pdma_rdata)
  );
  always_comb begin
    w_pop_acc   = pdma_fifo_pop && r_rdy;
    // a pop frees the slot this cycle, so a write into a full FIFO is still accepted
    w_wr_acc    = wr_en && (!r_full || w_pop_acc);
    w_lvl_nxt   = r_level + LW'(w_wr_acc) - LW'(w_pop_acc);
    w_tmo       = (TIMEOUT != 0) && (r_level != '0) && (r_cnt == CW'(TIMEOUT));
    w_state_nxt = r_state == ST_FILL ? ((w_lvl_nxt >= LW'(IRQ_THRESH) || w_tmo) ? ST_REQ : ST_FILL) :
                  r_state == ST_REQ  ? (w_pop_acc ? ST_DRAIN : ST_REQ) :
                                       (w_lvl_nxt == '0 ? ST_FILL : ST_DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_state <= ST_FILL;
      r_full  <= 1'b0;
      r_rdy   <= 1'b0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_wr_acc);
      r_rptr  <= r_rptr + AW'(w_pop_acc);
      r_level <= w_lvl_nxt;
      r_full  <= w_lvl_nxt == LW'(DEPTH);
      r_rdy   <= w_lvl_nxt != '0;
      r_state <= w_state_nxt;
      r_irq   <= w_state_nxt == ST_REQ;
      // a dropped write outranks a same-cycle clear
      r_ovf   <= (wr_en && !w_wr_acc) || (r_ovf && !clr_err);
      r_cnt   <= (r_state != ST_FILL || r_level == '0) ? '0 :
                 (r_cnt == CW'(TIMEOUT) ? r_cnt : r_cnt + 1'b1);
    end
  end
  assign full          = r_full;
  assign pdma_irq_req  = r_irq;
  assign pdma_data_rdy = r_rdy;
  assign level         = r_level;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_pdma_fifo_src.sv
// tb_pdma_fifo_src: scenario tests of pdma_fifo_src against a queue-based reference model
module tb_pdma_fifo_src;
  localparam int DW = 32, DEPTH = 16, TH = 8, TO = 64;
  logic          clk = 0, rstb = 0, wr_en = 0, pdma_fifo_pop = 0, clr_err = 0;
  logic [DW-1:0] wr_data = '0, pdma_rdata;
  logic          full, pdma_irq_req, pdma_data_rdy, overflow;
  logic [4:0]    level;
  logic [DW-1:0] q[$];
  logic          m_ovf = 0;
  int            vec = 0, err = 0;
  pdma_fifo_src #(.DATA_W(DW), .DEPTH(DEPTH), .IRQ_THRESH(TH), .TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .pdma_irq_req(pdma_irq_req), .pdma_data_rdy(pdma_data_rdy), .pdma_fifo_pop(pdma_fifo_pop),
    .pdma_rdata(pdma_rdata), .level(level), .overflow(overflow), .clr_err(clr_err)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic p, input logic c);
    bit pa, acc;
    wr_en = w; wr_data = d; pdma_fifo_pop = p; clr_err = c;
    pa  = p && q.size() > 0;
    acc = w && (q.size() < DEPTH || pa);
    if (pa) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (w && !acc) m_ovf = 1;
    else if (c) m_ovf = 0;
    @(posedge clk); #1;
    wr_en = 0; pdma_fifo_pop = 0; clr_err = 0;
  endtask
  task automatic do_reset();
    rstb = 0;
    cyc(0, 0, 0, 0);
    rstb = 1;
    q.delete();
    m_ovf = 0;
  endtask
  task automatic test_reset();
    do_reset();
    vec++; if (level !== 0)         begin err++; $display("FAIL reset_level got %0d want 0", level); end
    vec++; if (pdma_data_rdy !== 0) begin err++; $display("FAIL reset_rdy got %b want 0", pdma_data_rdy); end
    vec++; if (pdma_irq_req !== 0)  begin err++; $display("FAIL reset_irq got %b want 0", pdma_irq_req); end
    vec++; if (overflow !== 0)      begin err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    vec++; if (full !== 0)          begin err++; $display("FAIL reset_full got %b want 0", full); end
  endtask
  task automatic test_threshold(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) begin
      cyc(1, base + i, 0, 0);
      vec++; if (level !== 5'(i + 1)) begin err++; $display("FAIL thr_level got %0d want %0d", level, i + 1); end
      vec++; if (pdma_irq_req !== (i == 7)) begin err++; $display("FAIL thr_irq w%0d got %b want %b", i, pdma_irq_req, i == 7); end
    end
    for (int i = 0; i < 8; i++) begin
      vec++; if (pdma_rdata !== base + i) begin err++; $display("FAIL thr_data p%0d got %h want %h", i, pdma_rdata, base + i); end
      cyc(0, 0, 1, 0);
      vec++; if (pdma_irq_req !== 0) begin err++; $display("FAIL thr_irq_fall p%0d got %b want 0", i, pdma_irq_req); end
    end
    cyc(0, 0, 1, 0);
    vec++; if (level !== 0 || pdma_data_rdy !== 0) begin err++; $display("FAIL thr_trailing level %0d rdy %b want 0 0", level, pdma_data_rdy); end
    vec++; if (overflow !== 0) begin err++; $display("FAIL thr_trailing_ovf got %b want 0", overflow); end
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_timeout();
    int n = 0;
    cyc(1, 32'hAB, 0, 0);
    while (n < TO + 10) begin
      cyc(0, 0, 0, 0);
      n++;
      if (pdma_irq_req) break;
    end
    vec++; if (n !== TO + 1 || pdma_irq_req !== 1) begin err++; $display("FAIL timeout_delay got %0d irq %b want %0d", n, pdma_irq_req, TO + 1); end
    vec++; if (pdma_rdata !== 32'hAB) begin err++; $display("FAIL timeout_data got %h want ab", pdma_rdata); end
    cyc(0, 0, 1, 0);
    vec++; if (pdma_irq_req !== 0 || level !== 0) begin err++; $display("FAIL timeout_pop irq %b level %0d want 0 0", pdma_irq_req, level); end
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      cyc(1, $urandom, 0, 0);
      vec++; if (full !== (i == 15)) begin err++; $display("FAIL ovf_full w%0d got %b want %b", i, full, i == 15); end
    end
    vec++; if (overflow !== 0) begin err++; $display("FAIL ovf_early got %b want 0", overflow); end
    cyc(1, 32'hDEAD_BEEF, 0, 0);
    vec++; if (overflow !== 1 || level !== 16) begin err++; $display("FAIL ovf_set ovf %b level %0d want 1 16", overflow, level); end
    cyc(1, 32'hBAD0_0001, 0, 1);
    vec++; if (overflow !== m_ovf) begin err++; $display("FAIL ovf_set_wins got %b want %b", overflow, m_ovf); end
    cyc(0, 0, 0, 1);
    vec++; if (overflow !== 0) begin err++; $display("FAIL ovf_clr got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      vec++; if (pdma_rdata !== q[0]) begin err++; $display("FAIL ovf_drain p%0d got %h want %h", i, pdma_rdata, q[0]); end
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 1, 0);
    vec++; if (level !== 0 || full !== 0) begin err++; $display("FAIL ovf_empty level %0d full %b want 0 0", level, full); end
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_full_wr_pop();
    logic [DW-1:0] nw = $urandom;
    for (int i = 0; i < 16; i++) cyc(1, $urandom, 0, 0);
    vec++; if (pdma_rdata !== q[0]) begin err++; $display("FAIL fwp_head got %h want %h", pdma_rdata, q[0]); end
    cyc(1, nw, 1, 0);
    vec++; if (level !== 16 || full !== 1) begin err++; $display("FAIL fwp_level level %0d full %b want 16 1", level, full); end
    vec++; if (overflow !== 0) begin err++; $display("FAIL fwp_ovf got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      vec++; if (pdma_rdata !== q[0]) begin err++; $display("FAIL fwp_order p%0d got %h want %h", i, pdma_rdata, q[0]); end
      if (i == 15) begin vec++; if (pdma_rdata !== nw) begin err++; $display("FAIL fwp_last got %h want %h", pdma_rdata, nw); end end
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    do_reset();
    vec++; if ({level, full, pdma_irq_req, pdma_data_rdy, overflow} !== '0)
      begin err++; $display("FAIL midrst_outs level %0d full %b irq %b rdy %b ovf %b want all 0", level, full, pdma_irq_req, pdma_data_rdy, overflow); end
    test_threshold(32'h10);
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (q.size() > 0) begin
        vec++; if (pdma_rdata !== q[0]) begin err++; $display("FAIL rnd_data c%0d got %h want %h", i, pdma_rdata, q[0]); end
      end
      cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      vec++; if (level !== 5'(q.size()) || pdma_data_rdy !== (q.size() > 0) || full !== (q.size() == DEPTH))
        begin err++; $display("FAIL rnd_level c%0d level %0d rdy %b full %b want %0d", i, level, pdma_data_rdy, full, q.size()); end
      vec++; if (overflow !== m_ovf) begin err++; $display("FAIL rnd_ovf c%0d got %b want %b", i, overflow, m_ovf); end
    end
  endtask
  initial begin
    test_reset();
    test_threshold(32'h10);
    test_timeout();
    test_overflow();
    test_full_wr_pop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pdma_fifo_src.md
# pdma_fifo_src

Producer end of the PDMA FIFO handshake. Buffers sample words from the acquisition datapath in a show-ahead FIFO and raises `pdma_irq_req` once enough data is queued, or once a partial batch has waited too long. It then serves `pdma_fifo_pop` requests from the PDMA engine (or its simulation stand-in) until the FIFO is drained. It sits between the sample packer and the fabric-to-MSS PDMA interface.

## Interface

- `DATA_W`, 32: sample word width.
- `DEPTH`, 16: FIFO entries; must be a power of 2 and ≥ 4.
- `IRQ_THRESH`, 8: fill level that triggers a request; 1..DEPTH.
- `TIMEOUT`, 1024: cycles a non-empty, below-threshold FIFO waits before forcing a request; 0 disables the timeout.

Ports:

- `clk` in 1: single clock.
- `rstb` in 1: reset; synchronous, active-low.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in DATA_W: sample word.
- `full` out 1: FIFO full (level == DEPTH).
- `pdma_irq_req` out 1: request to start a drain burst.
- `pdma_data_rdy` out 1: head word valid (level != 0).
- `pdma_fifo_pop` in 1: consume the head word.
- `pdma_rdata` out DATA_W: head word (show-ahead).
- `level` out $clog2(DEPTH)+1: current fill count.
- `overflow` out 1: sticky; a write was dropped.
- `clr_err` in 1: clears `overflow`.

## Operation

- Storage is a DEPTH-entry RAM with write and read pointers $clog2(DEPTH) bits wide. Pointers wrap naturally. `level` is a separate counter.
- Write is accepted when `wr_en && (!full || pop_acc)`. Here `pop_acc = pdma_fifo_pop && pdma_data_rdy`.
- A write while full with no pop is dropped and sets `overflow`. `clr_err` clears it; if a drop and `clr_err` occur in the same cycle, set wins.
- A pop while empty is ignored and is not an error. The consumer issues one trailing pop after the last word by design.
- Simultaneous write and pop: both occur and `level` is unchanged. This includes the full case and the level==1 case.
- State machine, with state in a registered `state` and all outputs registered:
  - FILL: `pdma_irq_req`=0. Go to REQ when the next `level` ≥ IRQ_THRESH, or when the wait counter reaches TIMEOUT while level > 0.
  - REQ: `pdma_irq_req`=1. Go to DRAIN on the first `pop_acc`.
  - DRAIN: `pdma_irq_req`=0. Go to FILL when the next `level` == 0.
- Wait counter:
  - Clears in REQ and DRAIN, and whenever level == 0.
  - Otherwise, in FILL with level > 0, increments and saturates at TIMEOUT.
- Writes during DRAIN are accepted. The drain continues until empty.
- Reset (`rstb`=0 at a `clk` edge), including mid-burst: pointers, `level`, and counter go to 0. State goes to FILL. All outputs go low (`full`, `pdma_irq_req`, `pdma_data_rdy`, `overflow`). `pdma_rdata` becomes don't-care. Buffered data is discarded.

## Timing

- Write at edge N: `level` and `pdma_data_rdy` update after edge N. The word appears on `pdma_rdata` after edge N if the FIFO was empty.
- `pdma_irq_req` rises one cycle after the write that makes level reach IRQ_THRESH.
- `pdma_irq_req` falls one cycle after the first accepted pop.
- `pdma_rdata` is valid combinationally from the RAM read at `rd_ptr` whenever `pdma_data_rdy`=1. After an accepted pop it shows the next word in the following cycle.
- Timeout: with a single word written at edge N, `pdma_irq_req` rises after edge N+TIMEOUT+1.
- The consumer pops back-to-back, one word per cycle. The FIFO sustains this with zero bubbles.

## Structure

- A shared package (`pdma_pkg`) holds:
  - the state encoding FILL/REQ/DRAIN;
  - a `PDMA_DATA_W` constant, reused by the consumer side.
- Sub-module `pdma_fifo_mem`: a DEPTH×DATA_W RAM with registered write and asynchronous read, so it can map to fabric LSRAM/uSRAM.
- The FSM, pointers, and counters live in the top level.

## Test plan

- Reset check: after reset, `level`=0, `pdma_data_rdy`=0, `pdma_irq_req`=0, `overflow`=0, `full`=0.
- Threshold burst: write 8 words 0x10..0x17.
  - `pdma_irq_req` goes to 1 one cycle after the 8th write.
  - The consumer pops 8 back-to-back and reads 0x10..0x17 in order. `pdma_irq_req` falls after the first pop.
  - The 9th (trailing) pop is ignored; `level`=0 and state returns to FILL.
- Timeout: write one word 0xAB and wait.
  - `pdma_irq_req` rises exactly TIMEOUT+1 cycles later.
  - The pop returns 0xAB.
- Overflow: write 17 words with no pops.
  - `full`=1 at 16 and `overflow`=1 after the 17th.
  - `clr_err` clears `overflow`. The drain returns the first 16 words intact.
- Full with simultaneous write and pop: at `level`=16, assert `wr_en` and `pop` together.
  - `level` stays 16 and `overflow` stays 0.
  - The data order is preserved, with the new word last.
- Mid-drain reset: assert `rstb`=0 after 3 of 8 pops.
  - All outputs are 0 on the next cycle.
  - A subsequent 8-word burst behaves exactly like the threshold burst scenario.
